// File: rtl/yrv_aux_uart_pkg.sv
// Shared types and default constants for the YRV auxiliary UART receiver.
package yrv_aux_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 430;
  localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/yrv_aux_uart_fifo.sv
// Receive FIFO: power-of-two depth, wrapping pointers, head shown combinationally.
// A push while full is accepted only when a pop happens in the same cycle.
module yrv_aux_uart_fifo
  import yrv_aux_uart_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // NOTE: the storage array is deliberately not reset; the head output is forced to zero while empty instead.
  // Write the incoming byte at the tail.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/yrv_aux_uart_rx.sv
// YRV auxiliary UART receiver: 8N1, fixed clocks-per-bit, synchronous active-low reset.
// Define YRV_AUX_UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register is used and FIFO_DEPTH is ignored.
module yrv_aux_uart_rx
  import yrv_aux_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       aux_uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  // Reject illegal configurations at elaboration.
  if (CLKS_PER_BIT < 16 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("yrv_aux_uart_rx: illegal CLKS_PER_BIT or FIFO_DEPTH");
  end

  logic          rx_meta;
  logic          rx_s;
  rx_state_t     state;
  rx_state_t     state_d;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          timer_clr;
  logic          sample_bit;
  logic          push;
  logic          ferr_d;
  logic          overrun_d;
  logic          pop;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= aux_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  // Next-state and per-cycle control decisions.
  always_comb begin
    state_d    = state;
    timer_clr  = 1'b0;
    sample_bit = 1'b0;
    push       = 1'b0;
    ferr_d     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          timer_clr = 1'b1;
        end
      end
      START: begin
        if (timer == HALF_M1) begin
          timer_clr = 1'b1;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == FULL_M1) begin
          timer_clr  = 1'b1;
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer == FULL_M1) begin
          timer_clr = 1'b1;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer, bit index, LSB-first shift register and registered flag pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (timer_clr || state == IDLE || state == WAIT_HIGH) timer <= '0;
      else                                                  timer <= timer + 1'b1;
      if (state == IDLE)   bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + 1'b1;
      if (sample_bit) shift <= {rx_s, shift[7:1]};
      frame_err <= ferr_d;
      overrun   <= overrun_d;
    end
  end

  assign pop  = rx_valid && rx_ready;
  assign busy = (state != IDLE);

`ifdef YRV_AUX_UART_RX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  yrv_aux_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (rx_data)
  );

  assign rx_valid  = !fifo_empty;
  assign overrun_d = push && fifo_full && !pop;
`else
  logic [7:0] hold_data;
  logic       hold_valid;

  // Single holding register; a push while occupied keeps the old byte.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (push && (!hold_valid || pop)) begin
        hold_data  <= shift;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = hold_data;
  assign rx_valid  = hold_valid;
  assign overrun_d = push && hold_valid && !pop;
`endif

endmodule

// File: tb/tb_yrv_aux_uart_rx.sv
// Scoreboard bench for yrv_aux_uart_rx: stimulus queues expected bytes,
// a negedge monitor pops and compares on every accepted byte.
module tb_yrv_aux_uart_rx;

  localparam int CPB = 430;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       aux_uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  yrv_aux_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .aux_uart_rx (aux_uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         valid_cycles = 0;
  int         ferr_cycles = 0;
  int         ovr_cycles = 0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: count flag/valid cycles, compare each accepted byte with the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (rx_valid)  valid_cycles++;
      if (frame_err) ferr_cycles++;
      if (overrun)   ovr_cycles++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h, expected none", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(mon_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    aux_uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      aux_uart_rx = d[i];
      repeat (CPB) tick();
    end
    aux_uart_rx = stop_bit;
    repeat (CPB) tick();
    aux_uart_rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  // Watchdog: a hung run still reports and stops.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (3) tick();
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    resetn = 1'b1;
    repeat (5) tick();

    // Basic frame 0x55, consumer always ready.
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (20) tick();
    wait_drain("t1");
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_frame_err", ferr_cycles, 0);
    check("t1_overrun", ovr_cycles, 0);
    check("t1_busy", busy, 0);

    // Glitch: 100 low cycles is shorter than half a bit.
    aux_uart_rx = 1'b0;
    repeat (50) tick();
    check("t2_busy_during", busy, 1);
    repeat (50) tick();
    aux_uart_rx = 1'b1;
    repeat (400) tick();
    check("t2_busy_after", busy, 0);
    check("t2_valid_cycles", valid_cycles, 1);
    check("t2_frame_err", ferr_cycles, 0);
    check("t2_overrun", ovr_cycles, 0);

    // Framing error on 0xA3, then a clean 0x3C.
    send_frame(8'hA3, 1'b0);
    repeat (50) tick();
    check("t3_frame_err", ferr_cycles, 1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (20) tick();
    wait_drain("t3");
    check("t3_frame_err_total", ferr_cycles, 1);
    check("t3_busy", busy, 0);

`ifdef YRV_AUX_UART_RX_FIFO_EN
    // Overrun: five back-to-back bytes into a 4-entry FIFO with no consumer.
    rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    repeat (20) tick();
    check("t4_overrun", ovr_cycles, 1);
    check("t4_head_valid", rx_valid, 1);
    check("t4_head_data", rx_data, 8'h01);
    rx_ready = 1'b1;
    wait_drain("t4");
    check("t4_valid_after", rx_valid, 0);
`else
    // Overrun into the holding register: second byte dropped, first kept.
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) tick();
    check("t4_overrun", ovr_cycles, 1);
    check("t4_head_valid", rx_valid, 1);
    check("t4_head_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_drain("t4");
    check("t4_valid_after", rx_valid, 0);
`endif

    // Reset during data bit 3 of 0xFF, then a clean 0x81.
    aux_uart_rx = 1'b0;
    repeat (CPB) tick();
    aux_uart_rx = 1'b1;
    repeat (3 * CPB + CPB / 2) tick();
    check("t5_busy_mid_frame", busy, 1);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    check("t5_busy_after_reset", busy, 0);
    check("t5_valid_after_reset", rx_valid, 0);
    repeat (5 * CPB) tick();
    check("t5_no_flag", ferr_cycles, 1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (20) tick();
    wait_drain("t5");
    check("t5_overrun_total", ovr_cycles, 1);
    check("t5_frame_err_total", ferr_cycles, 1);

    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
